// File: rtl/piso_shifter_pkg.sv
// piso_shifter_pkg: shared types and constants for the
// parallel-in serial-out transmit shifter.
package piso_shifter_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic FILL_ARITH = 1'b0;
    localparam logic FILL_LOGIC = 1'b1;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    // Fill bit entering the top of the register on a right shift.
    function automatic logic fill_bit(
        input logic lr,
        input logic top
    );
        return (lr == FILL_LOGIC) ? 1'b0 : top;
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: frame bit counter with clear, enable
// and a flag marking the final bit position.
module piso_bit_cnt
    import piso_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;

    // Clear wins over enable so a frame end restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/piso_shifter.sv
// piso_shifter: loads a word via valid/ready and emits it
// one bit per enabled cycle, MSB- or LSB-first.
module piso_shifter
    import piso_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load_valid,
    output logic             Load_ready,
    input  logic             Msb_first,
    input  logic             L_R,
    input  logic             Shift_en,
    output logic             Dout,
    output logic             Dout_valid,
    output logic             Done,
    output logic             Busy,
    output logic [WIDTH-1:0] Sreg_o
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             dout_q;
    logic             dout_d;
    logic             dv_q;
    logic             dv_d;
    logic             done_q;
    logic             done_d;
    logic             msb_q;
    logic             msb_d;
    logic             lr_q;
    logic             lr_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt;

    piso_bit_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (Clk),
        .rst_n (Rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // State, shift register, serial output and latched mode bits.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            msb_q   <= 1'b0;
            lr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            msb_q   <= msb_d;
            lr_q    <= lr_d;
        end
    end

    // Next-state: capture on handshake, shift on enable, end after last bit.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        done_d  = 1'b0;
        msb_d   = msb_q;
        lr_d    = lr_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Load_valid) begin
                    sreg_d  = Din;
                    msb_d   = Msb_first;
                    lr_d    = L_R;
                    cnt_clr = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (Shift_en) begin
                    dv_d   = 1'b1;
                    cnt_en = 1'b1;
                    if (msb_q == DIR_MSB) begin
                        dout_d = sreg_q[WIDTH-1];
                        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        dout_d = sreg_q[0];
                        sreg_d = {fill_bit(lr_q, sreg_q[WIDTH-1]),
                                  sreg_q[WIDTH-1:1]};
                    end
                    if (cnt_last) begin
                        done_d  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Load_ready = (state_q == ST_IDLE);
    assign Busy       = (state_q == ST_SHIFT);
    assign Dout       = dout_q;
    assign Dout_valid = dv_q;
    assign Done       = done_q;
    assign Sreg_o     = sreg_q;

endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
- Parallel-in, serial-out shift register; the transmit-side counterpart of the existing serial-in, parallel-out `shifter`.
- Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled cycle on Dout.
- The bit order is selectable per word. The fill mode (arithmetic or logical) is also selectable per word and is visible on a parallel debug view.
- Sits between board/test logic and a serial link; Sreg_o and Busy drive board LEDs in top-level wrappers.

Parameters:
- WIDTH, 8: word width in bits; must be ≥2.
- CNT_W, $clog2(WIDTH): width of the bit counter.

Ports:
- Clk  input  1  single system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Din  input  WIDTH  parallel word to transmit.
- Load_valid  input  1  Din is valid for loading.
- Load_ready  output  1  block can accept a word.
- Msb_first  input  1  1 = send MSB first (shift left); 0 = send LSB first (shift right). Sampled at load.
- L_R  input  1  0 = arithmetic fill, 1 = logical fill. Sampled at load.
- Shift_en  input  1  advance one bit this cycle; low = stall.
- Dout  output  1  serial data bit.
- Dout_valid  output  1  Dout carries a new bit this cycle.
- Done  output  1  one-cycle pulse coincident with the last bit.
- Busy  output  1  a frame is in progress.
- Sreg_o  output  WIDTH  live shift-register contents (debug).

Behaviour:
- Reset: one clock, asynchronous active-low reset (Rst_n); Clk is the only clock.
  - While Rst_n is low: state=IDLE, sreg=0, cnt=0, Dout=0, Dout_valid=0, Done=0, Busy=0, latched mode bits=0.
  - Load_ready is derived from the state, so it reads 1 in reset.
- States: IDLE and SHIFT.
- Load_ready = (state==IDLE), driven combinationally from state only. Busy = (state==SHIFT).
- IDLE:
  - On Load_valid && Load_ready at edge N: sreg←Din, latch Msb_first and L_R, cnt←0, state←SHIFT.
  - Otherwise hold. Dout_valid=0 and Done=0.
- SHIFT, on an edge where Shift_en=1:
  - Dout←sreg[WIDTH-1] if MSB-first, else sreg[0]. Dout_valid←1.
  - MSB-first: sreg←{sreg[WIDTH-2:0], 0}. Arithmetic and logical are identical for left shifts.
  - LSB-first: sreg←{fill, sreg[WIDTH-1:1]}, where fill = sreg[WIDTH-1] if L_R=0, or 0 if L_R=1.
  - cnt←cnt+1.
  - If cnt==WIDTH-1 before the increment: Done←1, state←IDLE, cnt←0.
- SHIFT, on an edge where Shift_en=0: sreg, cnt and Dout hold. Dout_valid←0 and Done←0.
- Dout, Dout_valid and Done are registered.
- Latency:
  - The first bit is valid in the cycle after edge N+1 at the earliest, i.e. when Shift_en is high in the first SHIFT cycle.
  - With Shift_en held high, bits appear on edges N+1..N+WIDTH, and Done is high after edge N+WIDTH.
  - Load_ready returns high after edge N+WIDTH, so minimum throughput is one word per WIDTH+1 cycles.
- Load_valid in SHIFT is ignored: no capture and no effect on the frame in flight.
- Changes to Msb_first or L_R mid-frame are ignored; the latched copies are used.
- Din is don't-care outside the handshake cycle.
- Reset mid-frame aborts the frame immediately with no further bits or Done. After Rst_n rises, the block is in IDLE with Load_ready=1.
- Dout holds its last value after a frame; consumers qualify it with Dout_valid.

Decomposition:
- Package piso_shifter_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT);
  - constants FILL_ARITH=1'b0 and FILL_LOGIC=1'b1;
  - constants DIR_LSB=1'b0 and DIR_MSB=1'b1;
  - the default WIDTH.
- One sub-module, piso_bit_cnt: a CNT_W-bit counter with clear, enable and a last-bit flag (cnt==WIDTH-1).
- Shift and fill logic stays in piso_shifter.

Test Plan:
- MSB-first, WIDTH=8: Din=8'h1E, L_R=1, Shift_en=1.
  - Load accepted at edge N → Dout=0,0,0,1,1,1,1,0 on edges N+1..N+8.
  - Done=1 only after edge N+8; Load_ready=1 after edge N+8.
- LSB-first, arithmetic fill: Din=8'h80, Msb_first=0, L_R=0.
  - Dout=0,0,0,… for the first bits.
  - Sreg_o=8'hF0 after 3 shifts.
  - Repeat with L_R=1 → Sreg_o=8'h10 after 3 shifts.
- Stall: Din=8'hA5, MSB-first; drop Shift_en for 2 cycles after the 3rd bit.
  - Dout_valid=0 for 2 cycles; Dout and Sreg_o hold.
  - Remaining bits 0,0,1,0,1 follow.
  - Done arrives 2 cycles later than in the unstalled case.
- Load while busy: during the 8'h1E frame, pulse Load_valid with Din=8'hFF.
  - Load_ready=0 throughout; the serial stream is unchanged.
  - The 8'hFF word is not sent unless it is re-presented after Done.
- Reset mid-frame: assert Rst_n=0 asynchronously (not clock-aligned) after 4 bits.
  - Dout_valid=0, Done=0, Busy=0 and Sreg_o=0 immediately.
  - After release, a new load of 8'h3C transmits all 8 bits correctly.
- Back-to-back: hold Load_valid=1 with 8'hAA then 8'h55.
  - Second load accepted on the edge after the first word's last bit (9-cycle spacing).
  - Exactly 16 bits with Dout_valid=1, in the correct order.
